// File: rtl/wb4_fifo_stream_reader.sv
// Wishbone B4 master that drains a FIFO read port into a local skid buffer
// and presents the words as a valid/ready stream.
//
// Stream handshake: o_stream_valid/o_stream_data describe the buffer head.
// A word moves when o_stream_valid and i_stream_ready are both high on a
// rising edge. o_stream_valid never depends on i_stream_ready.
//
// Requests are only issued while (buffered words + requests in flight) is
// below P_BUF_DEPTH. Every accepted request therefore has a slot reserved,
// and the buffer cannot overflow even if the consumer stops.
module wb4_fifo_stream_reader #(
    parameter int P_DATA_MSB  = 31,
    parameter int P_CNT_MSB   = 15,
    parameter int P_BUF_DEPTH = 4
) (
    input  logic                i_wb4_sclk,
    input  logic                i_wb4_srst,
    input  logic                i_start,
    input  logic [P_CNT_MSB:0]  i_count,
    input  logic                i_abort,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_wb4_mcyc,
    output logic                o_wb4_mstb,
    input  logic                i_wb4_mack,
    input  logic [P_DATA_MSB:0] i_wb4_mdata,
    input  logic                i_wb4_mstall,
    output logic                o_stream_valid,
    input  logic                i_stream_ready,
    output logic [P_DATA_MSB:0] o_stream_data
);

    localparam int PTR_W = $clog2(P_BUF_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [P_CNT_MSB:0] count_q, count_d;
    logic [P_CNT_MSB:0] issued_q, issued_d;
    logic [OCC_W-1:0]   outst_q, outst_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mcyc_q, mcyc_d;
    logic               mstb_q, mstb_d;
    logic [P_DATA_MSB:0] buf_q [P_BUF_DEPTH];

    logic               accept;
    logic               ack_ok;
    logic               push;
    logic               pop;
    logic [OCC_W:0]     credit_sum;

    // Next-state, counters, buffer pointers and registered bus outputs.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        issued_d = issued_q;
        outst_d  = outst_q;

        accept = mstb_q & ~i_wb4_mstall;
        // Acks only count while a cycle is open and something is in flight,
        // so late acks after an abort are dropped here.
        ack_ok = mcyc_q & i_wb4_mack & (outst_q != '0);
        push   = ack_ok;
        pop    = (occ_q != '0) & i_stream_ready;

        occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    count_d  = i_count;
                    issued_d = '0;
                    outst_d  = '0;
                    state_d  = (i_count == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_abort) begin
                    // Abort beats a simultaneous accept: that request is not counted.
                    outst_d = '0;
                    state_d = ST_DONE;
                end else begin
                    issued_d = issued_q + (P_CNT_MSB+1)'(accept);
                    outst_d  = outst_q + OCC_W'(accept) - OCC_W'(ack_ok);
                    if (issued_d == count_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (i_abort) begin
                    outst_d = '0;
                    state_d = ST_DONE;
                end else begin
                    outst_d = outst_q - OCC_W'(ack_ok);
                    if (outst_d == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        credit_sum = (OCC_W+1)'(occ_d) + (OCC_W+1)'(outst_d);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        mcyc_d = (state_d == ST_REQ) || (state_d == ST_DRAIN);
        mstb_d = (state_d == ST_REQ) && (issued_d < count_d) &&
                 (credit_sum < (OCC_W+1)'(P_BUF_DEPTH));
    end

    // FSM state, counters and registered outputs; reset dominates everything.
    always_ff @(posedge i_wb4_sclk) begin
        if (i_wb4_srst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            issued_q <= '0;
            outst_q  <= '0;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mcyc_q   <= 1'b0;
            mstb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            outst_q  <= outst_d;
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mcyc_q   <= mcyc_d;
            mstb_q   <= mstb_d;
        end
    end

    // Buffer storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge i_wb4_sclk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= i_wb4_mdata;
        end
    end

    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_wb4_mcyc     = mcyc_q;
    assign o_wb4_mstb     = mstb_q;
    assign o_stream_valid = (occ_q != '0);
    assign o_stream_data  = buf_q[rd_ptr_q];

endmodule

// File: doc/wb4_fifo_stream_reader.md
WB4_FIFO_STREAM_READER -- requirements
Module: wb4_fifo_stream_reader

Interface
REQ-001 SHALL have parameter P_DATA_MSB, default 31, data word width-1 (matches FIFO read side P_DATA_O_MSB).
REQ-002 SHALL have parameter P_CNT_MSB, default 15, transfer-length counter width-1.
REQ-003 SHALL have parameter P_BUF_DEPTH, default 4, local skid buffer entries; power of two, >=2.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports as below.
REQ-005 i_wb4_sclk  input  1  clock, all logic on rising edge.
REQ-006 i_wb4_srst  input  1  synchronous active-high reset.
REQ-007 i_start  input  1  one-cycle request to begin a transfer of i_count words.
REQ-008 i_count  input  P_CNT_MSB+1  word count, sampled when i_start is accepted.
REQ-009 i_abort  input  1  terminate current transfer.
REQ-010 o_busy  output  1  high from accepted start until done/abort completes.
REQ-011 o_done  output  1  one-cycle pulse at transfer end (normal or abort).
REQ-012 o_wb4_mcyc  output  1  WB4 cycle to FIFO read port.
REQ-013 o_wb4_mstb  output  1  WB4 strobe to FIFO read port.
REQ-014 i_wb4_mack  input  1  WB4 ack from FIFO.
REQ-015 i_wb4_mdata  input  P_DATA_MSB+1  read data, valid when i_wb4_mack high.
REQ-016 i_wb4_mstall  input  1  FIFO stall (empty).
REQ-017 o_stream_valid  output  1  buffer head valid.
REQ-018 i_stream_ready  input  1  consumer accepts head.
REQ-019 o_stream_data  output  P_DATA_MSB+1  buffer head word.

Function
REQ-020 SHALL implement states IDLE, REQ, DRAIN, DONE.
REQ-021 IDLE: i_start with i_count!=0 -> REQ, latch count, clear issued counter; i_start with i_count==0 -> DONE, no cyc asserted.
REQ-022 i_start SHALL be ignored outside IDLE.
REQ-023 REQ: o_wb4_mcyc=1; o_wb4_mstb=1 iff issued<count and occupancy+outstanding<P_BUF_DEPTH.
REQ-024 Request accepted when mstb & ~i_wb4_mstall; accepted -> issued+1, outstanding+1 same edge.
REQ-025 Stalled strobe SHALL be held (not a transfer) until accepted or credit/count condition drops.
REQ-026 REQ -> DRAIN on edge where issued reaches count; DRAIN: mcyc=1, mstb=0.
REQ-027 DRAIN -> DONE when outstanding==0 (including ack arriving that cycle).
REQ-028 DONE: o_done=1 for exactly one cycle, mcyc=0, then IDLE; o_busy low in IDLE only.
REQ-029 Ack with mcyc=1 and outstanding>0 SHALL push i_wb4_mdata into buffer and decrement outstanding; acks otherwise ignored.
REQ-030 Simultaneous accept and ack SHALL leave outstanding unchanged.
REQ-031 Buffer: FIFO order; o_stream_valid = occupancy>0; pop on valid & ready; push and pop same cycle allowed, occupancy unchanged.
REQ-032 Latency: ack at edge t -> o_stream_valid and data visible after edge t (next cycle) when buffer was empty.
REQ-033 Credit rule guarantees no buffer overflow; pointers wrap modulo P_BUF_DEPTH.
REQ-034 Buffer contents SHALL remain poppable after DONE until consumed; next transfer appends.
REQ-035 i_abort in REQ/DRAIN: next edge mstb=0, mcyc=0, outstanding cleared, -> DONE; buffered words kept.
REQ-036 i_abort in IDLE/DONE SHALL have no effect; abort wins over simultaneous accept (that accept not counted).

Reset
REQ-037 On i_wb4_srst: state IDLE, counters and buffer pointers zero, o_busy=0, o_done=0, o_wb4_mcyc=0, o_wb4_mstb=0, o_stream_valid=0.
REQ-038 Reset mid-transfer SHALL discard outstanding acks and buffered data; reset dominates start/abort.

Verification
REQ-039 start, count=3, stall=0, ack 1 cycle after each accept, ready=1 -> 3 strobes, words D0,D1,D2 in order, o_done pulse 1 cycle after last ack, mcyc low in DONE.
REQ-040 count=8, ready=0 -> exactly 4 accepted strobes, then mstb=0; raise ready -> remaining 4 issued, 8 words delivered in order.
REQ-041 stall=1 for 5 cycles after start -> mstb held high, issued stays 0, no ack consumed; stall=0 -> transfer completes.
REQ-042 count=0 -> o_done pulse next cycle, mcyc never high, o_busy one cycle only.
REQ-043 abort after 2 of 6 accepted, acks pending -> mcyc/mstb low next edge, o_done pulse, late acks ignored, only acked words in buffer.
REQ-044 srst during DRAIN with 2 words buffered -> all outputs at reset values next cycle, o_stream_valid=0.
